regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
- Write-back unit that owns the register file's single write port (RegWrite/rd/writedata).
- Merges two result sources:
  - single-cycle ALU results, which have priority;
  - long-latency multiply/divide results, buffered in a small FIFO behind a valid/ready handshake.
- Keeps a pending-destination scoreboard so issue logic can detect RAW hazards on outstanding mul/div results.

Parameters:
- FIFO_DEPTH, 4, mul/div result FIFO entries; power of 2, at least 2.
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may lose to the ALU before it is forced through.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- alu_valid  input  1  ALU result present this cycle.
- alu_rd  input  5  ALU destination register.
- alu_data  input  32  ALU result.
- alu_stall  output  1  registered; when 1 the ALU result is not accepted and upstream must hold it and re-present it.
- md_valid  input  1  mul/div result offered.
- md_rd  input  5  mul/div destination register.
- md_data  input  32  mul/div result.
- md_ready  output  1  FIFO can accept; a push happens when md_valid && md_ready.
- issue_valid  input  1  a mul/div instruction is issued this cycle.
- issue_rd  input  5  destination of the issued mul/div.
- rs  input  5  source register probe for hazard check.
- rt  input  5  source register probe for hazard check.
- hazard_rs  output  1  combinational: busy[rs].
- hazard_rt  output  1  combinational: busy[rt].
- busy  output  32  scoreboard vector; bit 0 is always 0.
- RegWrite  output  1  registered write enable to the register file.
- rd  output  5  registered write address.
- writedata  output  32  registered write data.

Behaviour:
- Reset (asynchronous) clears:
  - RegWrite, rd, writedata → 0;
  - alu_stall → 0;
  - FIFO head, tail and count → 0; the starvation counter → 0;
  - busy → 0.
- Reset takes effect mid-operation: FIFO contents are discarded and no write occurs.
- md_ready = (count < FIFO_DEPTH). It does not rely on a same-cycle pop.
- Write selection each cycle, giving exactly one of three outcomes:
  - ALU wins: alu_stall==0 && alu_valid.
  - FIFO head pops: FIFO non-empty and the ALU does not win.
  - Idle: neither of the above.
- Latency: exactly 1 cycle. The winner's rd/data appear on rd/writedata at the next edge, with RegWrite=1.
- rd==0 handling:
  - An ALU winner with rd 0 produces RegWrite=0 and still consumes its slot.
  - A popped entry with rd 0 is discarded with RegWrite=0.
  - rd and writedata hold their previous values whenever RegWrite=0.
- Starvation counter:
  - Increments when the FIFO is non-empty and the ALU wins.
  - Resets to 0 on any pop, or whenever the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, alu_stall=1 for exactly the next cycle.
  - In that cycle the FIFO head pops, alu_valid is ignored, and the counter returns to 0.
- FIFO push and pop in the same cycle are allowed; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Pushes are accepted in arrival order and popped in FIFO order.
- Scoreboard set: issue_valid && issue_rd!=0 sets busy[issue_rd] at the next edge.
- Scoreboard clear: a FIFO pop of entry rd=r clears busy[r] at the same edge.
- If a set and a clear hit the same register in one cycle, the set wins.
- ALU writes never touch busy.
- ALU writes to a busy register are passed through unchanged; WAW ordering is the issue stage's responsibility.
- Hazard outputs:
  - hazard_rs/hazard_rt reflect current busy state and do not forward the same-cycle set.
  - A probe of register 0 always gives 0.

Test Plan:
- Reset then idle → RegWrite=0, rd=0, writedata=0, busy=0, md_ready=1 for 5 cycles. Asserting rst mid-burst with 3 FIFO entries → RegWrite=0 the next cycle, count=0, busy=0.
- ALU write only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle → next cycle RegWrite=1, rd=5, writedata=0xDEADBEEF; the cycle after, RegWrite=0. Repeat with alu_rd=0 → RegWrite stays 0.
- Mul/div path with scoreboard:
  - Stimulus: issue_valid with issue_rd=9; rs=9.
  - Cycle after issue: hazard_rs=1, busy[9]=1.
  - Push md_rd=9, md_data=0x12345678 with alu_valid=0 → next cycle RegWrite=1, rd=9, writedata=0x12345678, busy[9]=0.
- FIFO full and back-pressure:
  - Stimulus: push 4 entries (rd 1..4) with alu_valid held 1 (rd=10).
  - After the 4th push, md_ready=0 and a 5th md_valid is not accepted.
  - Writes observed: rd=10 four times.
- Starvation: with STARVE_LIMIT=8 and alu_valid held 1, after the FIFO becomes non-empty:
  - 8 ALU writes occur;
  - then alu_stall=1 for one cycle;
  - the FIFO head pops in FIFO order (rd 1 first);
  - the counter restarts.
- Set/clear collision: pop an entry with rd=7 in the same cycle as issue_valid with issue_rd=7 → busy[7]=1 afterwards, RegWrite=1, rd=7 the next cycle.

Source files
------------

// File: rtl/regfile_writeback.sv
// Write-back arbiter for the register file's single write port: ALU results take priority, mul/div results queue in a FIFO.
// Latency: 1 cycle from the winning source to RegWrite/rd/writedata. Also tracks busy registers for outstanding mul/div results.
// Backpressure: md_ready drops when the FIFO is full; alu_stall (registered) holds the ALU for one cycle when the FIFO is starved.
module regfile_writeback #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    output logic        md_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        hazard_rs,
    output logic        hazard_rt,
    output logic [31:0] busy,
    output logic        RegWrite,
    output logic [4:0]  rd,
    output logic [31:0] writedata
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    fifo_rd_q  [FIFO_DEPTH];
    logic [31:0]   fifo_dat_q [FIFO_DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          alu_stall_q, alu_stall_d;
    logic [31:0]   busy_q, busy_d;
    logic          regwrite_q, regwrite_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          alu_win;
    logic          fifo_ne;
    logic          push;
    logic          pop;
    logic [4:0]    head_rd;
    logic [31:0]   head_dat;

    // Full means count has reached depth; a same-cycle pop does not open a slot.
    assign md_ready  = (count_q != CW'(FIFO_DEPTH));
    assign alu_stall = alu_stall_q;
    assign busy      = busy_q;
    assign hazard_rs = busy_q[rs];
    assign hazard_rt = busy_q[rt];
    assign RegWrite  = regwrite_q;
    assign rd        = rd_q;
    assign writedata = wdata_q;

    // Arbitration, FIFO bookkeeping, starvation tracking and scoreboard next state.
    always_comb begin
        alu_win     = !alu_stall_q && alu_valid;
        fifo_ne     = (count_q != '0);
        pop         = fifo_ne && !alu_win;
        push        = md_valid && md_ready;
        head_rd     = fifo_rd_q[head_q];
        head_dat    = fifo_dat_q[head_q];

        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        starve_d    = starve_q;
        busy_d      = busy_q;
        regwrite_d  = 1'b0;
        rd_d        = rd_q;
        wdata_d     = wdata_q;

        // Writes to r0 are dropped but still consume the slot; address/data hold.
        if (alu_win) begin
            if (alu_rd != 5'd0) begin
                regwrite_d = 1'b1;
                rd_d       = alu_rd;
                wdata_d    = alu_data;
            end
        end else if (pop) begin
            if (head_rd != 5'd0) begin
                regwrite_d = 1'b1;
                rd_d       = head_rd;
                wdata_d    = head_dat;
            end
        end

        if (push) begin
            tail_d = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Count only cycles where a waiting FIFO head loses to the ALU.
        if (!fifo_ne || pop) begin
            starve_d = '0;
        end else if (alu_win) begin
            starve_d = starve_q + SW'(1);
        end
        alu_stall_d = (starve_d == SW'(STARVE_LIMIT));

        // Clear first so a same-cycle issue to the same register wins.
        if (pop) begin
            busy_d[head_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Control and write-port registers; reset discards queued results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            alu_stall_q <= 1'b0;
            busy_q      <= '0;
            regwrite_q  <= 1'b0;
            rd_q        <= '0;
            wdata_q     <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            alu_stall_q <= alu_stall_d;
            busy_q      <= busy_d;
            regwrite_q  <= regwrite_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
        end
    end

    // FIFO storage; validity is tracked by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[tail_q]  <= md_rd;
            fifo_dat_q[tail_q] <= md_data;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: vector table for single-cycle behaviour plus multi-cycle sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Sequences cover reset, hazards, FIFO full, starvation, mid-burst reset and set/clear collision.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        hazard_rs;
    logic        hazard_rt;
    logic [31:0] busy;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] writedata;

    int checks = 0;
    int errors = 0;

    regfile_writeback #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rs(rs), .rt(rt),
        .hazard_rs(hazard_rs), .hazard_rt(hazard_rt), .busy(busy),
        .RegWrite(RegWrite), .rd(rd), .writedata(writedata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        iv;
        logic [4:0]  ird;
        logic        ewe;
        logic [4:0]  erd;
        logic [31:0] ewd;
        logic [31:0] ebusy;
        logic        emdr;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        md_valid = 1'b0;  md_rd = '0;  md_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        rs = '0; rt = '0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();

        // av ard adat  mv mrd mdat  iv ird  ewe erd ewd  ebusy  emdr
        vt[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        1'b1};
        vt[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd5,  32'hDEADBEEF, 32'h0,        1'b1};
        vt[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd5,  32'hDEADBEEF, 32'h0,        1'b1};
        vt[3]  = '{1'b1, 5'd0,  32'h11,       1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd5,  32'hDEADBEEF, 32'h0,        1'b1};
        vt[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd5,  32'hDEADBEEF, 32'h200,      1'b1};
        vt[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h12345678, 1'b0, 5'd0,  1'b0, 5'd5,  32'hDEADBEEF, 32'h200,      1'b1};
        vt[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd9,  32'h12345678, 32'h0,        1'b1};
        vt[7]  = '{1'b1, 5'd3,  32'h33,       1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd3,  32'h33,       32'h0,        1'b1};
        vt[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b0, 5'd3,  32'h33,       32'h80000000, 1'b1};
        vt[9]  = '{1'b1, 5'd4,  32'h44,       1'b1, 5'd31, 32'hAA,       1'b0, 5'd0,  1'b1, 5'd4,  32'h44,       32'h80000000, 1'b1};
        vt[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd31, 32'hAA,       32'h0,        1'b1};
        vt[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hBB,       1'b0, 5'd0,  1'b0, 5'd31, 32'hAA,       32'h0,        1'b1};
        vt[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd31, 32'hAA,       32'h0,        1'b1};

        // Reset then idle: everything stays cleared for 5 cycles.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            chk("idle_we",    32'(RegWrite),  32'd0);
            chk("idle_rd",    32'(rd),        32'd0);
            chk("idle_wd",    writedata,      32'd0);
            chk("idle_busy",  busy,           32'd0);
            chk("idle_mdrdy", 32'(md_ready),  32'd1);
            chk("idle_stall", 32'(alu_stall), 32'd0);
            tick();
        end

        // Vector table: each row is applied for one edge and the registered result checked.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            alu_valid = vt[i].av; alu_rd = vt[i].ard; alu_data = vt[i].adat;
            md_valid = vt[i].mv;  md_rd = vt[i].mrd;  md_data = vt[i].mdat;
            issue_valid = vt[i].iv; issue_rd = vt[i].ird;
            tick();
            chk($sformatf("vec%0d_we", i),    32'(RegWrite), 32'(vt[i].ewe));
            chk($sformatf("vec%0d_rd", i),    32'(rd),       32'(vt[i].erd));
            chk($sformatf("vec%0d_wd", i),    writedata,     vt[i].ewd);
            chk($sformatf("vec%0d_busy", i),  busy,          vt[i].ebusy);
            chk($sformatf("vec%0d_mdrdy", i), 32'(md_ready), 32'(vt[i].emdr));
        end

        // Hazard probes: no same-cycle forwarding, r0 never hazards.
        do_reset();
        rs = 5'd9; rt = 5'd12;
        issue_valid = 1'b1; issue_rd = 5'd9;
        #1;
        chk("haz_rs_nofwd", 32'(hazard_rs), 32'd0);
        tick();
        issue_valid = 1'b0;
        #1;
        chk("haz_rs_set", 32'(hazard_rs), 32'd1);
        chk("haz_rt_clr", 32'(hazard_rt), 32'd0);
        chk("haz_busy9",  busy,           32'h200);
        rt = 5'd0;
        #1;
        chk("haz_rt_r0",  32'(hazard_rt), 32'd0);

        // FIFO fills behind a continuous ALU stream, then starvation forces pops.
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0;
        for (int i = 1; i <= 4; i++) begin
            md_valid = 1'b1; md_rd = 5'(i); md_data = 32'h100 + 32'(i);
            #1;
            chk("full_rdy_pre", 32'(md_ready), 32'd1);
            tick();
            chk("full_alu_we", 32'(RegWrite), 32'd1);
            chk("full_alu_rd", 32'(rd),       32'd10);
        end
        chk("full_rdy0", 32'(md_ready), 32'd0);
        md_valid = 1'b1; md_rd = 5'd5; md_data = 32'h105;
        for (int k = 5; k <= 9; k++) begin
            tick();
            md_valid = 1'b0;
            chk("starve1_rd",    32'(rd),        32'd10);
            chk("starve1_wd",    writedata,      32'hA0);
            chk("starve1_stall", 32'(alu_stall), (k == 9) ? 32'd1 : 32'd0);
            chk("starve1_rdy",   32'(md_ready),  32'd0);
        end
        tick();
        chk("starve1_pop_rd",    32'(rd),        32'd1);
        chk("starve1_pop_wd",    writedata,      32'h101);
        chk("starve1_pop_stall", 32'(alu_stall), 32'd0);
        chk("starve1_pop_rdy",   32'(md_ready),  32'd1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("starve2_rd",    32'(rd),        32'd10);
            chk("starve2_stall", 32'(alu_stall), (k == 8) ? 32'd1 : 32'd0);
        end
        tick();
        chk("starve2_pop_rd", 32'(rd),   32'd2);
        chk("starve2_pop_wd", writedata, 32'h102);
        alu_valid = 1'b0;
        tick();
        chk("drain_rd3", 32'(rd), 32'd3);
        tick();
        chk("drain_rd4", 32'(rd),   32'd4);
        chk("drain_wd4", writedata, 32'h104);
        tick();
        chk("drain_empty_we", 32'(RegWrite), 32'd0);

        // Reset mid-burst with 3 queued entries and 3 busy registers.
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hB0;
        for (int i = 1; i <= 3; i++) begin
            md_valid = 1'b1; md_rd = 5'(20 + i); md_data = 32'h200 + 32'(i);
            issue_valid = 1'b1; issue_rd = 5'(20 + i);
            tick();
        end
        chk("mid_pre_busy", busy,           32'h00E00000);
        chk("mid_pre_we",   32'(RegWrite),  32'd1);
        chk("mid_pre_rdy",  32'(md_ready),  32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we",   32'(RegWrite),  32'd0);
        chk("mid_rst_busy", busy,           32'd0);
        chk("mid_rst_rd",   32'(rd),        32'd0);
        idle_in();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_after_we",   32'(RegWrite), 32'd0);
            chk("mid_after_busy", busy,          32'd0);
        end

        // Pop of rd 7 collides with a new issue to rd 7: the set wins.
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        chk("coll_busy_set", busy, 32'h80);
        md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h77;
        tick();
        md_valid = 1'b0;
        chk("coll_push_we", 32'(RegWrite), 32'd0);
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        chk("coll_we",   32'(RegWrite), 32'd1);
        chk("coll_rd",   32'(rd),       32'd7);
        chk("coll_wd",   writedata,     32'h77);
        chk("coll_busy", busy,          32'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
